// File: rtl/ac97_pkg.sv
// Shared types and constants for the AC97 command scheduler.
package ac97_pkg;

    localparam int unsigned SLOT_W = 20;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;

    // slot 0 tag bit positions
    localparam int unsigned TAG_FRAME = 15;
    localparam int unsigned TAG_SLOT1 = 14;
    localparam int unsigned TAG_SLOT2 = 13;
    localparam int unsigned TAG_SLOT3 = 12;
    localparam int unsigned TAG_SLOT4 = 11;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_CMD  = 2'd1,
        ST_GAP  = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // codec initialisation sequence, issued in index order
    localparam cmd_t ROM_0 = '{addr: 7'h02, data: 16'h0000}; // unmute line out
    localparam cmd_t ROM_1 = '{addr: 7'h04, data: 16'h0000}; // unmute headphones
    localparam cmd_t ROM_2 = '{addr: 7'h10, data: 16'h0808}; // line-in gain
    localparam cmd_t ROM_3 = '{addr: 7'h18, data: 16'h0808}; // PCM out volume

endpackage

// File: rtl/ac97_init_rom.sv
// Combinational lookup of the codec init sequence.
module ac97_init_rom
    import ac97_pkg::*;
#(
    parameter int unsigned IDX_W = 3
) (
    input  logic [IDX_W-1:0] i_idx,
    output cmd_t             o_entry_c
);

    // index to {addr, data}; out-of-range indices read as zero
    always_comb begin
        o_entry_c = '0;
        case (i_idx)
            IDX_W'(0): o_entry_c = ROM_0;
            IDX_W'(1): o_entry_c = ROM_1;
            IDX_W'(2): o_entry_c = ROM_2;
            IDX_W'(3): o_entry_c = ROM_3;
            default:   o_entry_c = '0;
        endcase
    end

endmodule

// File: rtl/ac97_cmd_scheduler.sv
// Frame-synchronous AC97 command scheduler: codec init sequence followed by
// arbitrated runtime register writes, one command per frame with a gap frame after.
module ac97_cmd_scheduler
    import ac97_pkg::*;
#(
    parameter int unsigned WAIT_FRAMES = 16,
    parameter int unsigned INIT_LEN    = 4
) (
    input  logic              BIT_CLK,
    input  logic              SYSTEM_RESET,
    input  logic              FRAME_START,
    input  logic              PCM_VALID,
    input  logic              CMD_REQ,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_DATA,
    output logic              CMD_ACK,
    output logic              INIT_DONE,
    output logic              BUSY,
    output logic [SLOT_W-1:0] slots0,
    output logic [SLOT_W-1:0] slots1,
    output logic [SLOT_W-1:0] slots2
);

    localparam int unsigned WCNT_W = (WAIT_FRAMES > 1) ? $clog2(WAIT_FRAMES) : 1;
    localparam int unsigned IDX_W  = (INIT_LEN > 0) ? $clog2(INIT_LEN + 1) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [IDX_W-1:0]    r_init_idx;
    logic                r_init_done;
    logic                r_ack;
    logic                r_busy;
    logic [SLOT_W-1:0]   r_slot0;
    logic [SLOT_W-1:0]   r_slot1;
    logic [SLOT_W-1:0]   r_slot2;

    logic                w_wait_last;
    logic                w_init_pending;
    logic                w_load_init;
    logic                w_accept;
    logic                w_wait_inc;
    logic                w_set_done;
    logic                w_done_nxt;
    logic                w_tag_cmd;
    logic [SLOT_W-1:0]   w_slot0_nxt;
    cmd_t                w_rom;

    assign w_wait_last    = (r_wait_cnt == WCNT_W'(WAIT_FRAMES - 1));
    assign w_init_pending = (r_init_idx < IDX_W'(INIT_LEN));

    ac97_init_rom #(.IDX_W(IDX_W)) u_rom (
        .i_idx     (r_init_idx),
        .o_entry_c (w_rom)
    );

    // state register
    always_ff @(posedge BIT_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) r_state <= ST_WAIT;
        else              r_state <= w_state_nxt;
    end

    // next state: transitions only on frame boundaries
    always_comb begin
        w_state_nxt = r_state;
        if (FRAME_START) begin
            unique case (r_state)
                ST_WAIT: if (w_wait_last) w_state_nxt = ST_CMD;
                ST_CMD:  w_state_nxt = ST_GAP;
                ST_GAP:  w_state_nxt = (w_init_pending || CMD_REQ) ? ST_CMD : ST_IDLE;
                ST_IDLE: if (CMD_REQ) w_state_nxt = ST_CMD;
                default: w_state_nxt = ST_WAIT;
            endcase
        end
    end

    // output decode: datapath actions taken at this frame boundary
    always_comb begin
        w_load_init = 1'b0;
        w_accept    = 1'b0;
        w_wait_inc  = 1'b0;
        w_set_done  = 1'b0;
        if (FRAME_START) begin
            unique case (r_state)
                ST_WAIT: begin
                    if (w_wait_last) w_load_init = 1'b1;
                    else             w_wait_inc  = 1'b1;
                end
                ST_CMD:  ;
                ST_GAP: begin
                    if (w_init_pending) begin
                        w_load_init = 1'b1;
                    end else begin
                        w_set_done = 1'b1;
                        w_accept   = CMD_REQ;
                    end
                end
                ST_IDLE: w_accept = CMD_REQ;
                default: ;
            endcase
        end
        w_done_nxt = r_init_done | w_set_done;
        w_tag_cmd  = w_load_init | w_accept;

        w_slot0_nxt            = '0;
        w_slot0_nxt[TAG_FRAME] = 1'b1;
        w_slot0_nxt[TAG_SLOT1] = w_tag_cmd;
        w_slot0_nxt[TAG_SLOT2] = w_tag_cmd;
        w_slot0_nxt[TAG_SLOT3] = PCM_VALID & w_done_nxt;
        w_slot0_nxt[TAG_SLOT4] = PCM_VALID & w_done_nxt;
    end

    // counters, flags and slot words
    always_ff @(posedge BIT_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            r_wait_cnt  <= '0;
            r_init_idx  <= '0;
            r_init_done <= 1'b0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b1;
            r_slot0     <= '0;
            r_slot1     <= '0;
            r_slot2     <= '0;
        end else begin
            r_ack       <= w_accept;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_init_done <= w_done_nxt;
            if (w_wait_inc) r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            if (w_load_init) begin
                r_init_idx <= r_init_idx + IDX_W'(1);
                r_slot1    <= {1'b0, w_rom.addr, 12'h000};
                r_slot2    <= {w_rom.data, 4'h0};
            end
            if (w_accept) begin
                r_slot1 <= {1'b0, CMD_ADDR, 12'h000};
                r_slot2 <= {CMD_DATA, 4'h0};
            end
            if (FRAME_START) r_slot0 <= w_slot0_nxt;
        end
    end

    assign CMD_ACK   = r_ack;
    assign INIT_DONE = r_init_done;
    assign BUSY      = r_busy;
    assign slots0    = r_slot0;
    assign slots1    = r_slot1;
    assign slots2    = r_slot2;

endmodule

// File: tb/tb_ac97_cmd_scheduler.sv
// Directed + randomized bench for ac97_cmd_scheduler with a frame-level reference model.
module tb_ac97_cmd_scheduler;

    localparam int W  = 16;
    localparam int L  = 4;
    localparam int FP = 256;

    logic        BIT_CLK;
    logic        SYSTEM_RESET;
    logic        FRAME_START;
    logic        PCM_VALID;
    logic        CMD_REQ;
    logic [6:0]  CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        CMD_ACK;
    logic        INIT_DONE;
    logic        BUSY;
    logic [19:0] slots0;
    logic [19:0] slots1;
    logic [19:0] slots2;

    ac97_cmd_scheduler #(.WAIT_FRAMES(W), .INIT_LEN(L)) dut (
        .BIT_CLK      (BIT_CLK),
        .SYSTEM_RESET (SYSTEM_RESET),
        .FRAME_START  (FRAME_START),
        .PCM_VALID    (PCM_VALID),
        .CMD_REQ      (CMD_REQ),
        .CMD_ADDR     (CMD_ADDR),
        .CMD_DATA     (CMD_DATA),
        .CMD_ACK      (CMD_ACK),
        .INIT_DONE    (INIT_DONE),
        .BUSY         (BUSY),
        .slots0       (slots0),
        .slots1       (slots1),
        .slots2       (slots2)
    );

    initial BIT_CLK = 1'b0;
    always #5 BIT_CLK = ~BIT_CLK;

    int cyc = 0;
    always @(posedge BIT_CLK) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          mf;          // frame starts seen since reset release
    int          last_cmd;    // frame start that loaded the most recent command
    logic [19:0] e_s1, e_s2;
    logic        e_done;
    bit          hold_b2b;
    bit          rnd;
    int          ack_q[$];
    logic [22:0] rom_m [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mf       = 0;
        last_cmd = -100;
        e_s1     = '0;
        e_s2     = '0;
        e_done   = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_slots0"}, 32'(slots0), 32'h0);
        chk({tag, "_slots1"}, 32'(slots1), 32'h0);
        chk({tag, "_slots2"}, 32'(slots2), 32'h0);
        chk({tag, "_ack"}, 32'(CMD_ACK), 32'h0);
        chk({tag, "_done"}, 32'(INIT_DONE), 32'h0);
        chk({tag, "_busy"}, 32'(BUSY), 32'h1);
    endtask

    // One full frame: pulse FRAME_START, predict the frame contents, check, then
    // act as the requester for the rest of the frame while checking stability.
    task automatic frame(input logic pcm);
        logic        req, cmd, acc, e_busy, stable_ok, pv;
        logic [19:0] e0;
        logic [22:0] ent;
        int          pick;
        @(negedge BIT_CLK);
        PCM_VALID   = pcm;
        FRAME_START = 1'b1;
        req = CMD_REQ;
        mf++;
        e_done = (mf >= W + 2 * L);
        cmd = 1'b0;
        acc = 1'b0;
        if (mf >= W && mf < W + 2 * L && ((mf - W) % 2 == 0)) begin
            ent      = rom_m[(mf - W) / 2];
            cmd      = 1'b1;
            e_s1     = {1'b0, ent[22:16], 12'h000};
            e_s2     = {ent[15:0], 4'h0};
            last_cmd = mf;
        end else if (e_done && req && mf >= last_cmd + 2) begin
            cmd      = 1'b1;
            acc      = 1'b1;
            e_s1     = {1'b0, CMD_ADDR, 12'h000};
            e_s2     = {CMD_DATA, 4'h0};
            last_cmd = mf;
        end
        pv     = pcm & e_done;
        e0     = {4'b0000, 1'b1, cmd, cmd, pv, pv, 11'b0};
        e_busy = !(e_done && !cmd && mf != last_cmd + 1);

        @(negedge BIT_CLK);
        FRAME_START = 1'b0;
        if (CMD_ACK === 1'b1) ack_q.push_back(cyc);
        chk($sformatf("f%0d_ack", mf), 32'(CMD_ACK), 32'(acc));
        chk($sformatf("f%0d_slots0", mf), 32'(slots0), 32'(e0));
        chk($sformatf("f%0d_slots1", mf), 32'(slots1), 32'(e_s1));
        chk($sformatf("f%0d_slots2", mf), 32'(slots2), 32'(e_s2));
        chk($sformatf("f%0d_done", mf), 32'(INIT_DONE), 32'(e_done));
        chk($sformatf("f%0d_busy", mf), 32'(BUSY), 32'(e_busy));

        if (acc) begin
            if (hold_b2b) begin
                CMD_ADDR = 7'($urandom);
                CMD_DATA = 16'($urandom);
            end else begin
                CMD_REQ = 1'b0;
            end
        end
        pick = (rnd && CMD_REQ == 1'b0) ? int'($urandom_range(0, 3)) : 3;
        stable_ok = 1'b1;
        for (int i = 0; i < FP - 2; i++) begin
            @(negedge BIT_CLK);
            if (i == 10 && pick == 0) begin
                CMD_REQ  = 1'b1;
                CMD_ADDR = 7'($urandom);
                CMD_DATA = 16'($urandom);
            end
            if (i == 20 && pick == 1) CMD_REQ = 1'b1;
            if (i == 60 && pick == 1) CMD_REQ = 1'b0;
            if (CMD_ACK !== 1'b0 || slots0 !== e0 || slots1 !== e_s1 ||
                slots2 !== e_s2 || INIT_DONE !== e_done || BUSY !== e_busy)
                stable_ok = 1'b0;
        end
        chk($sformatf("f%0d_stable", mf), 32'(stable_ok), 32'h1);
    endtask

    initial begin
        rom_m[0] = {7'h02, 16'h0000};
        rom_m[1] = {7'h04, 16'h0000};
        rom_m[2] = {7'h10, 16'h0808};
        rom_m[3] = {7'h18, 16'h0808};
        SYSTEM_RESET = 1'b1;
        FRAME_START  = 1'b0;
        PCM_VALID    = 1'b0;
        CMD_REQ      = 1'b0;
        CMD_ADDR     = '0;
        CMD_DATA     = '0;
        hold_b2b     = 1'b0;
        rnd          = 1'b0;
        model_reset();
        repeat (3) @(negedge BIT_CLK);
        chk_reset_values("rst");

        // request held from reset, then a back-to-back second request
        CMD_REQ  = 1'b1;
        CMD_ADDR = 7'h2C;
        CMD_DATA = 16'hBB80;
        @(negedge BIT_CLK);
        SYSTEM_RESET = 1'b0;
        chk("post_rst_slots0", 32'(slots0), 32'h0);
        hold_b2b = 1'b1;
        ack_q.delete();
        for (int f = 1; f <= 25; f++) frame(1'b1);
        hold_b2b = 1'b0;
        frame(1'b1);
        chk("ack_count", 32'(ack_q.size()), 32'd2);
        chk("ack_gap", (ack_q.size() >= 2) ? 32'(ack_q[1] - ack_q[0]) : 32'hFFFF_FFFF, 32'(2 * FP));

        // randomized runtime traffic
        rnd = 1'b1;
        for (int f = 0; f < 30; f++) begin
            hold_b2b = 1'($urandom_range(0, 1));
            frame(1'($urandom_range(0, 1)));
        end
        rnd      = 1'b0;
        hold_b2b = 1'b0;
        CMD_REQ  = 1'b0;

        // reset in the middle of the third init command, with a pending request
        SYSTEM_RESET = 1'b1;
        @(negedge BIT_CLK);
        SYSTEM_RESET = 1'b0;
        model_reset();
        CMD_REQ  = 1'b1;
        CMD_ADDR = 7'h33;
        CMD_DATA = 16'h1234;
        for (int f = 1; f <= 20; f++) frame(1'b1);
        SYSTEM_RESET = 1'b1;
        #1;
        chk_reset_values("midrst");
        @(negedge BIT_CLK);
        FRAME_START = 1'b1;
        @(negedge BIT_CLK);
        FRAME_START  = 1'b0;
        SYSTEM_RESET = 1'b0;
        model_reset();
        for (int f = 1; f <= 25; f++) frame(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
